// File: rtl/sms_reset_pkg.sv
// Shared types and default parameters for the SMS reset sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package sms_reset_pkg;

    // Sequencer states; the encodings are visible on the debug port.
    typedef enum logic [1:0] {
        HOLD    = 2'd0,
        STRETCH = 2'd1,
        RUN     = 2'd2
    } state_t;

    localparam int DEF_SYNC_STAGES     = 2;
    localparam int DEF_STRETCH_CYCLES  = 16;
    localparam int DEF_DEBOUNCE_CYCLES = 8;

endpackage

// File: rtl/sms_sync_debounce.sv
// Synchronizes an async bouncy input and accepts a level only after it is stable.
// Latency: SYNC_STAGES + DEBOUNCE_CYCLES edges from input change to dout change.
// Backpressure: none; free-running, glitches shorter than DEBOUNCE_CYCLES are dropped.
module sms_sync_debounce
    import sms_reset_pkg::*;
#(
    parameter int   SYNC_STAGES     = DEF_SYNC_STAGES,
    parameter int   DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter logic RESET_VAL       = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic synced,
    output logic dout
);

    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);

    logic [SYNC_STAGES-1:0] sync;
    logic [DW-1:0]          dcnt;

    // Metastability chain; resets to the idle level so a reset never looks like a press.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync <= {SYNC_STAGES{RESET_VAL}};
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], din};
        end
    end

    assign synced = sync[SYNC_STAGES-1];

    // Count consecutive cycles of disagreement; the toggle and the clear share the
    // edge on which the count would reach DEBOUNCE_CYCLES, so dcnt never holds that value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dcnt <= '0;
            dout <= RESET_VAL;
        end else if (synced == dout) begin
            dcnt <= '0;
        end else if (dcnt == DW'(DEBOUNCE_CYCLES - 1)) begin
            dcnt <= '0;
            dout <= ~dout;
        end else begin
            dcnt <= dcnt + 1'b1;
        end
    end

endmodule

// File: rtl/sms_reset_sequencer.sv
// Turns the raw -RESET pin and console RESET key into a clean, stretched reset pair.
// Latency: release after SYNC_STAGES+1+STRETCH_CYCLES edges; key press asserts after SYNC_STAGES+DEBOUNCE_CYCLES+1.
// Backpressure: none; assertion via rst_n is immediate and asynchronous.
module sms_reset_sequencer
    import sms_reset_pkg::*;
#(
    parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
    parameter int STRETCH_CYCLES  = DEF_STRETCH_CYCLES,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       key_reset_n,
    output logic       reset_n_o,
    output logic       reset_o,
    output logic       ready,
    output logic [1:0] state
);

    localparam int SW = $clog2(STRETCH_CYCLES + 1);

    logic [SYNC_STAGES-1:0] rel_sync;
    logic                   rel_ok;
    logic                   key_sync;
    logic                   key_db;
    state_t                 state_q;
    logic [SW-1:0]          scnt;

    // Release synchronizer: cleared asynchronously, fills with ones after rst_n rises.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rel_sync <= '0;
        end else begin
            rel_sync <= {rel_sync[SYNC_STAGES-2:0], 1'b1};
        end
    end

    assign rel_ok = rel_sync[SYNC_STAGES-1];

    sms_sync_debounce #(
        .SYNC_STAGES     (SYNC_STAGES),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .RESET_VAL       (1'b1)
    ) u_key (
        .clk    (clk),
        .rst_n  (rst_n),
        .din    (key_reset_n),
        .synced (key_sync),
        .dout   (key_db)
    );

    // Sequencer: outputs are loaded alongside each transition, so they always equal
    // (state == RUN) one register later than the decision, never combinational.
    // Leaving HOLD also requires the raw synced key to be idle: a key already held at
    // rst_n release has not yet reached key_db, and must not start a stretch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= HOLD;
            scnt      <= '0;
            reset_n_o <= 1'b0;
            ready     <= 1'b0;
        end else begin
            case (state_q)
                HOLD: begin
                    if (rel_ok && key_db && key_sync) begin
                        state_q <= STRETCH;
                        scnt    <= '0;
                    end
                end
                STRETCH: begin
                    if (!key_db) begin
                        state_q <= HOLD;
                    end else begin
                        if (scnt != SW'(STRETCH_CYCLES)) begin
                            scnt <= scnt + 1'b1;
                        end
                        if (scnt == SW'(STRETCH_CYCLES - 1)) begin
                            state_q   <= RUN;
                            reset_n_o <= 1'b1;
                            ready     <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (!key_db) begin
                        state_q   <= HOLD;
                        reset_n_o <= 1'b0;
                        ready     <= 1'b0;
                    end
                end
                default: begin
                    state_q   <= HOLD;
                    reset_n_o <= 1'b0;
                    ready     <= 1'b0;
                end
            endcase
        end
    end

    assign reset_o = ~reset_n_o;
    assign state   = state_q;

endmodule

// File: tb/tb_sms_reset_sequencer.sv
// Directed bench for the SMS reset sequencer with an expected-state scoreboard.
// Latency: n/a.
// Backpressure: n/a.
module tb_sms_reset_sequencer;

    logic       clk;
    logic       rst_n;
    logic       key_reset_n;
    logic       reset_n_o;
    logic       reset_o;
    logic       ready;
    logic [1:0] state;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string      tag;
        logic [1:0] st;
    } exp_t;

    exp_t sb[$];

    localparam logic [1:0] S_HOLD    = 2'd0;
    localparam logic [1:0] S_STRETCH = 2'd1;
    localparam logic [1:0] S_RUN     = 2'd2;

    sms_reset_sequencer #(
        .SYNC_STAGES     (2),
        .STRETCH_CYCLES  (16),
        .DEBOUNCE_CYCLES (8)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .key_reset_n (key_reset_n),
        .reset_n_o   (reset_n_o),
        .reset_o     (reset_o),
        .ready       (ready),
        .state       (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Pop the oldest expectation and compare every output against it.
    task automatic check_now();
        exp_t e;
        logic rn_exp;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_empty: observed no expectation, required one");
            return;
        end
        e = sb.pop_front();
        rn_exp = (e.st == S_RUN);
        checks++;
        assert (state === e.st) else begin
            errors++;
            $error("FAIL %s state: observed=%0d expected=%0d", e.tag, state, e.st);
        end
        checks++;
        assert (reset_n_o === rn_exp) else begin
            errors++;
            $error("FAIL %s reset_n_o: observed=%b expected=%b", e.tag, reset_n_o, rn_exp);
        end
        checks++;
        assert (reset_o === ~rn_exp) else begin
            errors++;
            $error("FAIL %s reset_o: observed=%b expected=%b", e.tag, reset_o, ~rn_exp);
        end
        checks++;
        assert (ready === rn_exp) else begin
            errors++;
            $error("FAIL %s ready: observed=%b expected=%b", e.tag, ready, rn_exp);
        end
    endtask

    // Expect a state after the next rising edge, then sample 1 time unit later.
    task automatic step(input string tag, input logic [1:0] st);
        exp_t e;
        e.tag = tag;
        e.st  = st;
        sb.push_back(e);
        @(posedge clk);
        #1;
        check_now();
    endtask

    task automatic now_expect(input string tag, input logic [1:0] st);
        exp_t e;
        e.tag = tag;
        e.st  = st;
        sb.push_back(e);
        check_now();
    endtask

    initial begin
        rst_n       = 1'b0;
        key_reset_n = 1'b1;

        // Power-up: held in reset for 5 cycles.
        #1;
        now_expect("reset_initial", S_HOLD);
        for (int i = 0; i < 5; i++) step("reset_held", S_HOLD);

        // Release: HOLD for edges 1-2, STRETCH 3-18, RUN from 19.
        rst_n = 1'b1;
        for (int e = 1; e <= 22; e++) begin
            if (e <= 2)       step("pwr_hold", S_HOLD);
            else if (e <= 18) step("pwr_stretch", S_STRETCH);
            else              step("pwr_run", S_RUN);
        end

        // Key press in RUN for 30 cycles: HOLD from edge 11.
        key_reset_n = 1'b0;
        for (int e = 1; e <= 30; e++) begin
            if (e <= 10) step("key_fall_run", S_RUN);
            else         step("key_fall_hold", S_HOLD);
        end
        // Key release: STRETCH at edge 11, RUN at edge 27.
        key_reset_n = 1'b1;
        for (int e = 1; e <= 29; e++) begin
            if (e <= 10)      step("key_rise_hold", S_HOLD);
            else if (e <= 26) step("key_rise_stretch", S_STRETCH);
            else              step("key_rise_run", S_RUN);
        end

        // Bounce rejection: 7-cycle pulse, then 3/3 chatter for 30 cycles.
        key_reset_n = 1'b0;
        for (int i = 0; i < 7; i++) step("pulse7", S_RUN);
        key_reset_n = 1'b1;
        for (int i = 0; i < 10; i++) step("pulse7_after", S_RUN);
        for (int b = 0; b < 5; b++) begin
            key_reset_n = 1'b0;
            for (int i = 0; i < 3; i++) step("bounce_low", S_RUN);
            key_reset_n = 1'b1;
            for (int i = 0; i < 3; i++) step("bounce_high", S_RUN);
        end
        for (int i = 0; i < 10; i++) step("bounce_settle", S_RUN);

        // Async reset mid-RUN, dropped between edges.
        #2;
        rst_n = 1'b0;
        #1;
        now_expect("async_mid_run", S_HOLD);
        for (int i = 0; i < 3; i++) step("async_held", S_HOLD);

        // Rerun the sequence, then press the key 5 cycles into STRETCH.
        rst_n = 1'b1;
        for (int e = 1; e <= 7; e++) begin
            if (e <= 2) step("rerun_hold", S_HOLD);
            else        step("rerun_stretch", S_STRETCH);
        end
        key_reset_n = 1'b0;
        for (int e = 1; e <= 20; e++) begin
            if (e <= 10) step("key_in_stretch", S_STRETCH);
            else         step("key_in_stretch_hold", S_HOLD);
        end
        key_reset_n = 1'b1;
        for (int e = 1; e <= 29; e++) begin
            if (e <= 10)      step("stretch_rel_hold", S_HOLD);
            else if (e <= 26) step("stretch_rel_full", S_STRETCH);
            else              step("stretch_rel_run", S_RUN);
        end

        // Key held across a rst_n release.
        rst_n       = 1'b0;
        key_reset_n = 1'b0;
        #1;
        now_expect("keyrst_assert", S_HOLD);
        for (int i = 0; i < 5; i++) step("keyrst_held", S_HOLD);
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) step("keyrst_key_down", S_HOLD);
        key_reset_n = 1'b1;
        for (int e = 1; e <= 28; e++) begin
            if (e <= 10)      step("keyrst_rel_hold", S_HOLD);
            else if (e <= 26) step("keyrst_rel_stretch", S_STRETCH);
            else              step("keyrst_rel_run", S_RUN);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
